// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data to physical-memory arbiter.
// Grant selection lives here so the tie-break rule reads in one place.
package mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IFETCH,
        ARB_DACCESS
    } lc3b_arb_state;

    typedef enum logic {
        ARB_INSTR,
        ARB_DATA
    } lc3b_arb_port;

    typedef struct packed {
        logic          write;
        lc3b_word      address;
        lc3b_word      wdata;
        lc3b_mem_wmask byte_enable;
    } arb_txn_t;

    localparam lc3b_mem_wmask BE_ALL = 2'b11;

    // Policy 0: data wins ties; otherwise alternate away from the last tie winner.
    function automatic lc3b_arb_port pick_port(input logic         pend_i,
                                               input logic         pend_d,
                                               input int unsigned  policy,
                                               input lc3b_arb_port last);
        if (!pend_d)
            return ARB_INSTR;
        if (!pend_i)
            return ARB_DATA;
        if (policy == 0)
            return ARB_DATA;
        return (last == ARB_DATA) ? ARB_INSTR : ARB_DATA;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side split ports and the physical-memory port of the arbiter.
// slave: the arbiter; master: the environment driving requests and memory.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic          instruction_request;
    lc3b_word      instruction_address;
    lc3b_word      instr;
    logic          instruction_response;

    logic          data_request;
    logic          write_enable;
    lc3b_word      mem_address;
    lc3b_word      write_data;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_rdata;
    logic          data_response;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    lc3b_word      pmem_wdata;
    lc3b_mem_wmask pmem_byte_enable;
    lc3b_word      pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  instruction_request, instruction_address,
        output instr, instruction_response,
        input  data_request, write_enable, mem_address, write_data, mem_byte_enable,
        output mem_rdata, data_response,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output instruction_request, instruction_address,
        input  instr, instruction_response,
        output data_request, write_enable, mem_address, write_data, mem_byte_enable,
        input  mem_rdata, data_response,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/mem_arbiter_resp.sv
// Per-port response side: served flag (the four-phase response) and read-data register.
module arb_port_resp
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     request,
    input  logic     complete,
    input  logic     is_read,
    input  lc3b_word rdata_in,
    output logic     served,
    output lc3b_word rdata
);

    // A completion only counts while the requester still holds its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served <= 1'b0;
            rdata  <= '0;
        end else begin
            if (!request)
                served <= 1'b0;
            else if (complete)
                served <= 1'b1;

            if (complete && request && is_read)
                rdata <= rdata_in;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the fetch and MEM-stage ports onto one physical-memory port.
// One transaction in flight at a time; pmem_* come straight from registers.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ARB_POLICY = 0
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    lc3b_arb_state state;
    lc3b_arb_port  last_grant;
    lc3b_arb_port  grant;
    arb_txn_t      txn;
    logic          rd_strobe;
    logic          wr_strobe;

    logic          served_i;
    logic          served_d;
    logic          pend_i;
    logic          pend_d;
    logic          complete_i;
    logic          complete_d;
    lc3b_word      instr_q;
    lc3b_word      rdata_q;

    assign pend_i     = bus.instruction_request & ~served_i;
    assign pend_d     = bus.data_request & ~served_d;
    assign grant      = pick_port(pend_i, pend_d, ARB_POLICY, last_grant);
    assign complete_i = (state == ARB_IFETCH)  & bus.pmem_resp;
    assign complete_d = (state == ARB_DACCESS) & bus.pmem_resp;

    // Grants are taken only from IDLE, so the completion edge never re-grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_DATA;
            txn        <= '0;
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pend_i || pend_d) begin
                        if (pend_i && pend_d && (ARB_POLICY != 0))
                            last_grant <= grant;
                        if (grant == ARB_DATA) begin
                            state           <= ARB_DACCESS;
                            txn.write       <= bus.write_enable;
                            txn.address     <= bus.mem_address;
                            txn.wdata       <= bus.write_data;
                            txn.byte_enable <= bus.write_enable ? bus.mem_byte_enable : BE_ALL;
                            rd_strobe       <= ~bus.write_enable;
                            wr_strobe       <= bus.write_enable;
                        end else begin
                            state           <= ARB_IFETCH;
                            txn.write       <= 1'b0;
                            txn.address     <= bus.instruction_address;
                            txn.wdata       <= '0;
                            txn.byte_enable <= BE_ALL;
                            rd_strobe       <= 1'b1;
                            wr_strobe       <= 1'b0;
                        end
                    end
                end
                ARB_IFETCH, ARB_DACCESS: begin
                    if (bus.pmem_resp) begin
                        state     <= ARB_IDLE;
                        rd_strobe <= 1'b0;
                        wr_strobe <= 1'b0;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    rd_strobe <= 1'b0;
                    wr_strobe <= 1'b0;
                end
            endcase
        end
    end

    arb_port_resp u_instr_resp (
        .clk      (clk),
        .rst      (rst),
        .request  (bus.instruction_request),
        .complete (complete_i),
        .is_read  (1'b1),
        .rdata_in (bus.pmem_rdata),
        .served   (served_i),
        .rdata    (instr_q)
    );

    arb_port_resp u_data_resp (
        .clk      (clk),
        .rst      (rst),
        .request  (bus.data_request),
        .complete (complete_d),
        .is_read  (~txn.write),
        .rdata_in (bus.pmem_rdata),
        .served   (served_d),
        .rdata    (rdata_q)
    );

    assign bus.instr                = instr_q;
    assign bus.instruction_response = served_i;
    assign bus.mem_rdata            = rdata_q;
    assign bus.data_response        = served_d;

    assign bus.pmem_read        = rd_strobe;
    assign bus.pmem_write       = wr_strobe;
    assign bus.pmem_address     = txn.address;
    assign bus.pmem_wdata       = txn.wdata;
    assign bus.pmem_byte_enable = txn.byte_enable;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized two-port traffic scored against a reference memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic        wr;
        logic [15:0] val;
    } dexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus0();
    mem_arbiter_if bus1();

    mem_arbiter #(.ARB_POLICY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_arbiter #(.ARB_POLICY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        rand_done = 1'b0;
    logic [15:0] exp_i[$];
    dexp_t       exp_d[$];
    logic [15:0] ref_mem[logic [15:0]];
    logic [15:0] pstore[logic [15:0]];

    logic [69:0] outs0;
    assign outs0 = {bus0.instr, bus0.instruction_response, bus0.mem_rdata, bus0.data_response,
                    bus0.pmem_read, bus0.pmem_write, bus0.pmem_address, bus0.pmem_wdata,
                    bus0.pmem_byte_enable};

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rom(input logic [15:0] a);
        return (a * 16'd3) ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] ref_get(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    function automatic logic [15:0] pget(input logic [15:0] a);
        return pstore.exists(a) ? pstore[a] : ~a;
    endfunction

    // Monitor: pops the scoreboard on each rising response.
    initial begin
        logic        pi;
        logic        pd;
        logic [15:0] last_rd;
        dexp_t       e;
        pi = 1'b0;
        pd = 1'b0;
        last_rd = 16'h0000;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus0.instruction_response && !pi) begin
                    if (exp_i.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL instr_unexpected: got response with instr %0h, expected none", bus0.instr);
                    end else
                        chk("instr_data", 72'(bus0.instr), 72'(exp_i.pop_front()));
                end
                if (bus0.data_response && !pd) begin
                    if (exp_d.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_unexpected: got response with rdata %0h, expected none", bus0.mem_rdata);
                    end else begin
                        e = exp_d.pop_front();
                        if (e.wr)
                            chk("write_keeps_rdata", 72'(bus0.mem_rdata), 72'(last_rd));
                        else begin
                            chk("data_read", 72'(bus0.mem_rdata), 72'(e.val));
                            last_rd = e.val;
                        end
                    end
                end
            end
            pi = bus0.instruction_response;
            pd = bus0.data_response;
        end
    end

    task automatic mem_responder();
        int          cnt;
        logic [15:0] a;
        cnt = -1;
        while (!rand_done) begin
            tick();
            if (bus0.pmem_resp) begin
                bus0.pmem_resp = 1'b0;
            end else if (bus0.pmem_read || bus0.pmem_write) begin
                if (cnt < 0) begin
                    cnt = $urandom_range(0, 3);
                    chk("strobe_exclusive", 72'(bus0.pmem_read & bus0.pmem_write), 72'(0));
                    if (bus0.pmem_read)
                        chk("read_byte_enable", 72'(bus0.pmem_byte_enable), 72'(2'b11));
                end
                if (cnt == 0) begin
                    a = bus0.pmem_address;
                    if (bus0.pmem_write)
                        pstore[a] = merge(pget(a), bus0.pmem_wdata, bus0.pmem_byte_enable);
                    else
                        bus0.pmem_rdata = a[15] ? pget(a) : rom(a);
                    bus0.pmem_resp = 1'b1;
                    cnt = -1;
                end else
                    cnt--;
            end else if ($urandom_range(0, 15) == 0) begin
                bus0.pmem_rdata = 16'($urandom);
                bus0.pmem_resp  = 1'b1;
            end
        end
        bus0.pmem_resp = 1'b0;
    endtask

    task automatic instr_port(input int n);
        logic [15:0] a;
        logic        ab;
        logic        done;
        logic        granted;
        for (int t = 0; t < n; t++) begin
            a  = 16'($urandom_range(0, 255));
            ab = ($urandom_range(0, 5) == 0);
            bus0.instruction_address = a;
            bus0.instruction_request = 1'b1;
            if (!ab)
                exp_i.push_back(rom(a));
            done = 1'b0;
            granted = 1'b0;
            for (int c = 0; c < 80 && !done; c++) begin
                tick();
                if (ab) begin
                    if (bus0.pmem_read && !bus0.pmem_address[15]) done = 1'b1;
                end else if (bus0.instruction_response) begin
                    done = 1'b1;
                end else begin
                    if (bus0.pmem_read && !bus0.pmem_address[15]) granted = 1'b1;
                    if (granted) bus0.instruction_address = 16'($urandom_range(0, 255));
                end
            end
            chk("instr_wait", 72'(done), 72'(1));
            bus0.instruction_request = 1'b0;
            tick();
            for (int c = 0; c < 20 && bus0.pmem_read && !bus0.pmem_address[15]; c++)
                tick();
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic data_port(input int n);
        logic [15:0] a;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        wr;
        logic        done;
        logic        granted;
        for (int t = 0; t < n; t++) begin
            a  = 16'h8000 | 16'($urandom_range(0, 15));
            wd = 16'($urandom);
            be = 2'($urandom_range(1, 3));
            wr = 1'($urandom_range(0, 1));
            bus0.mem_address     = a;
            bus0.write_data      = wd;
            bus0.mem_byte_enable = be;
            bus0.write_enable    = wr;
            bus0.data_request    = 1'b1;
            if (wr) begin
                ref_mem[a] = merge(ref_get(a), wd, be);
                exp_d.push_back('{1'b1, 16'h0000});
            end else
                exp_d.push_back('{1'b0, ref_get(a)});
            done = 1'b0;
            granted = 1'b0;
            for (int c = 0; c < 80 && !done; c++) begin
                tick();
                if (bus0.data_response) done = 1'b1;
                else begin
                    if ((bus0.pmem_read || bus0.pmem_write) && bus0.pmem_address[15]) granted = 1'b1;
                    if (granted) begin
                        bus0.mem_address     = 16'h8000 | 16'($urandom_range(0, 15));
                        bus0.write_data      = 16'($urandom);
                        bus0.write_enable    = 1'($urandom_range(0, 1));
                        bus0.mem_byte_enable = 2'($urandom);
                    end
                end
            end
            chk("data_wait", 72'(done), 72'(1));
            bus0.data_request = 1'b0;
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        bus0.instruction_request = 1'b0; bus0.instruction_address = '0;
        bus0.data_request = 1'b0; bus0.write_enable = 1'b0; bus0.mem_address = '0;
        bus0.write_data = '0; bus0.mem_byte_enable = '0; bus0.pmem_rdata = '0; bus0.pmem_resp = 1'b0;
        bus1.instruction_request = 1'b0; bus1.instruction_address = '0;
        bus1.data_request = 1'b0; bus1.write_enable = 1'b0; bus1.mem_address = '0;
        bus1.write_data = '0; bus1.mem_byte_enable = '0; bus1.pmem_rdata = '0; bus1.pmem_resp = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 72'(outs0), 72'(0));
        rst = 1'b0;
        tick();

        // Reset during a write, then a normal fetch of 0x0000.
        bus0.data_request = 1'b1; bus0.write_enable = 1'b1; bus0.mem_address = 16'h8010;
        bus0.write_data = 16'h1111; bus0.mem_byte_enable = 2'b01;
        tick();
        chk("t1_write_strobe", 72'({bus0.pmem_write, bus0.pmem_read}), 72'(2'b10));
        #1 rst = 1'b1;
        #1;
        chk("t1_rst_write_drop", 72'(bus0.pmem_write), 72'(0));
        chk("t1_rst_outputs", 72'(outs0), 72'(0));
        bus0.data_request = 1'b0; bus0.write_enable = 1'b0;
        tick();
        rst = 1'b0;
        bus0.instruction_address = 16'h0000; bus0.instruction_request = 1'b1;
        tick();
        chk("t1_fetch_strobe", 72'({bus0.pmem_read, bus0.pmem_address}), 72'({1'b1, 16'h0000}));
        bus0.pmem_rdata = 16'h0F0F; bus0.pmem_resp = 1'b1;
        tick();
        bus0.pmem_resp = 1'b0;
        chk("t1_fetch_resp", 72'({bus0.instruction_response, bus0.instr}), 72'({1'b1, 16'h0F0F}));
        bus0.instruction_request = 1'b0;
        tick();

        // Single fetch with resp in cycle 3.
        bus0.instruction_address = 16'h0060; bus0.instruction_request = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("t2_strobe_c%0d", c),
                72'({bus0.pmem_read, bus0.pmem_write, bus0.pmem_address, bus0.pmem_byte_enable}),
                72'({1'b1, 1'b0, 16'h0060, 2'b11}));
            chk($sformatf("t2_no_resp_c%0d", c), 72'(bus0.instruction_response), 72'(0));
        end
        bus0.pmem_rdata = 16'h1234; bus0.pmem_resp = 1'b1;
        tick();
        bus0.pmem_resp = 1'b0;
        chk("t2_resp_c4", 72'({bus0.instruction_response, bus0.instr, bus0.pmem_read}),
            72'({1'b1, 16'h1234, 1'b0}));
        bus0.instruction_request = 1'b0;
        @(negedge clk);
        chk("t2_resp_hold", 72'(bus0.instruction_response), 72'(1));
        tick();
        chk("t2_resp_c5", 72'({bus0.instruction_response, bus0.instr}), 72'({1'b0, 16'h1234}));

        // Tie with data-priority policy.
        bus0.instruction_address = 16'h0040; bus0.instruction_request = 1'b1;
        bus0.mem_address = 16'h8000; bus0.write_enable = 1'b0; bus0.data_request = 1'b1;
        tick();
        chk("t3_data_first", 72'({bus0.pmem_read, bus0.pmem_address}), 72'({1'b1, 16'h8000}));
        bus0.pmem_rdata = 16'h5555; bus0.pmem_resp = 1'b1;
        tick();
        bus0.pmem_resp = 1'b0;
        chk("t3_data_resp", 72'({bus0.data_response, bus0.mem_rdata}), 72'({1'b1, 16'h5555}));
        chk("t3_no_regrant", 72'(bus0.pmem_read), 72'(0));
        bus0.data_request = 1'b0;
        tick();
        chk("t3_instr_second", 72'({bus0.pmem_read, bus0.pmem_address}), 72'({1'b1, 16'h0040}));
        bus0.pmem_rdata = 16'h4040; bus0.pmem_resp = 1'b1;
        tick();
        bus0.pmem_resp = 1'b0;
        chk("t3_instr_resp", 72'({bus0.instruction_response, bus0.instr}), 72'({1'b1, 16'h4040}));
        bus0.instruction_request = 1'b0;
        tick();

        // Byte-lane write; inputs scrambled mid-flight.
        bus0.data_request = 1'b1; bus0.write_enable = 1'b1; bus0.mem_address = 16'h0102;
        bus0.write_data = 16'hBEEF; bus0.mem_byte_enable = 2'b10;
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk($sformatf("t5_write_c%0d", c),
                72'({bus0.pmem_read, bus0.pmem_write, bus0.pmem_address, bus0.pmem_wdata, bus0.pmem_byte_enable}),
                72'({1'b0, 1'b1, 16'h0102, 16'hBEEF, 2'b10}));
            bus0.mem_address = 16'hFFFF; bus0.write_data = 16'h0000;
            bus0.write_enable = 1'b0; bus0.mem_byte_enable = 2'b01;
        end
        bus0.pmem_rdata = 16'h9999; bus0.pmem_resp = 1'b1;
        tick();
        bus0.pmem_resp = 1'b0;
        chk("t5_write_resp", 72'({bus0.data_response, bus0.mem_rdata}), 72'({1'b1, 16'h5555}));
        bus0.data_request = 1'b0;
        tick();

        // Abandoned fetch with a data read queued behind it.
        bus0.instruction_address = 16'h0010; bus0.instruction_request = 1'b1;
        tick();
        chk("t6_fetch_c1", 72'({bus0.pmem_read, bus0.pmem_address}), 72'({1'b1, 16'h0010}));
        bus0.mem_address = 16'h8004; bus0.write_enable = 1'b0; bus0.data_request = 1'b1;
        tick();
        bus0.instruction_request = 1'b0;
        chk("t6_fetch_c2", 72'({bus0.pmem_read, bus0.pmem_address}), 72'({1'b1, 16'h0010}));
        tick();
        chk("t6_fetch_c3", 72'({bus0.pmem_read, bus0.pmem_address}), 72'({1'b1, 16'h0010}));
        bus0.pmem_rdata = 16'hDEAD; bus0.pmem_resp = 1'b1;
        tick();
        bus0.pmem_resp = 1'b0;
        chk("t6_abandon_c4", 72'({bus0.instruction_response, bus0.instr, bus0.pmem_read, bus0.pmem_write}),
            72'({1'b0, 16'h4040, 1'b0, 1'b0}));
        tick();
        chk("t6_data_grant", 72'({bus0.pmem_read, bus0.pmem_address}), 72'({1'b1, 16'h8004}));
        bus0.pmem_rdata = 16'h7777; bus0.pmem_resp = 1'b1;
        tick();
        bus0.pmem_resp = 1'b0;
        chk("t6_data_resp", 72'({bus0.instruction_response, bus0.instr, bus0.data_response, bus0.mem_rdata}),
            72'({1'b0, 16'h4040, 1'b1, 16'h7777}));
        bus0.data_request = 1'b0;
        tick();

        // Round-robin instance: two tie rounds.
        for (int r = 0; r < 2; r++) begin
            logic [15:0] ia;
            logic [15:0] da;
            ia = 16'h0100 + 16'(r);
            da = 16'h8100 + 16'(r);
            bus1.instruction_address = ia; bus1.mem_address = da; bus1.write_enable = 1'b0;
            bus1.instruction_request = 1'b1; bus1.data_request = 1'b1;
            tick();
            chk($sformatf("t4_r%0d_first", r), 72'({bus1.pmem_read, bus1.pmem_address}),
                72'({1'b1, (r == 0) ? ia : da}));
            bus1.pmem_rdata = 16'h00A0; bus1.pmem_resp = 1'b1;
            tick();
            bus1.pmem_resp = 1'b0;
            tick();
            chk($sformatf("t4_r%0d_second", r), 72'({bus1.pmem_read, bus1.pmem_address}),
                72'({1'b1, (r == 0) ? da : ia}));
            bus1.pmem_resp = 1'b1;
            tick();
            bus1.pmem_resp = 1'b0;
            chk($sformatf("t4_r%0d_resps", r),
                72'({bus1.instruction_response, bus1.data_response}), 72'(2'b11));
            bus1.instruction_request = 1'b0; bus1.data_request = 1'b0;
            tick();
            tick();
        end

        // Randomized traffic on the data-priority instance.
        rst = 1'b1;
        tick();
        chk("reset2_outputs", 72'(outs0), 72'(0));
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        fork
            begin
                fork
                    instr_port(60);
                    data_port(60);
                join
                repeat (10) tick();
                rand_done = 1'b1;
            end
            mem_responder();
        join
        tick();
        chk("instr_queue_drained", 72'(exp_i.size()), 72'(0));
        chk("data_queue_drained", 72'(exp_d.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
